instruction_fetch: RTL and testbench

- Program-counter and fetch stage directly upstream of the decoder/controller.
- Holds the PC and fetches 32-bit instructions from the instruction cache over a req/ready handshake.
- Presents each instruction with a valid flag to the controller.
- Redirects the PC when the branch/unconditionalBranch flags resolve taken.

---
 rtl/instruction_fetch.sv | 65 ++++++
 tb/tb_instruction_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and fetch stage feeding the decoder/controller.
// Ports: clock/resetN (async active-low); icacheReq/icacheAddr/icacheReady/icacheData
// form the cache handshake; instruction/instructionValid/pc present the fetched word;
// stall holds it; redirectValid/branch/unconditionalBranch/aluZero/branchOffset redirect the PC.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  resetN,
    output logic                  icacheReq,
    output logic [ADDR_WIDTH-1:0] icacheAddr,
    input  logic                  icacheReady,
    input  logic [31:0]           icacheData,
    output logic [31:0]           instruction,
    output logic                  instructionValid,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  stall,
    input  logic                  redirectValid,
    input  logic                  branch,
    input  logic                  unconditionalBranch,
    input  logic                  aluZero,
    input  logic [ADDR_WIDTH-1:0] branchOffset
);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DELIVER} state_t;
    state_t state, nextState;
    logic [ADDR_WIDTH-1:0] fetchPc, flushAddr, target;
    logic taken;
    assign taken = redirectValid & (unconditionalBranch | (branch & aluZero));
    assign target = pc + (branchOffset << 2);
    assign icacheReq = (state == FETCH) || (state == FLUSH);
    // a flushed request must keep its original address until the cache answers it
    assign icacheAddr = (state == FLUSH) ? flushAddr : fetchPc;
    assign instructionValid = state == DELIVER;
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   nextState = icacheReady ? (taken ? FETCH : DELIVER) : (taken ? FLUSH : FETCH);
            FLUSH:   nextState = icacheReady ? FETCH : FLUSH;
            DELIVER: nextState = (taken || !stall) ? FETCH : DELIVER;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else state <= nextState;
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetchPc     <= RESET_PC;
            flushAddr   <= RESET_PC;
            pc          <= RESET_PC;
            instruction <= '0;
        end else begin
            if (state == FETCH && !icacheReady && taken) flushAddr <= fetchPc;
            if (state == FETCH && icacheReady && !taken) begin
                instruction <= icacheData;
                pc          <= fetchPc;
            end
            if (taken && state != IDLE) fetchPc <= target;
            else if (state == DELIVER && !stall) fetchPc <= pc + ADDR_WIDTH'(4);
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a behavioural model.
module tb_instruction_fetch;
    logic        clock = 0;
    logic        resetN = 1;
    logic        icacheReq;
    logic [63:0] icacheAddr;
    logic        icacheReady = 1;
    logic [31:0] icacheData = 0;
    logic [31:0] instruction;
    logic        instructionValid;
    logic [63:0] pc;
    logic        stall = 0;
    logic        redirectValid = 0;
    logic        branch = 0;
    logic        unconditionalBranch = 0;
    logic        aluZero = 0;
    logic [63:0] branchOffset = 0;
    int nChecks = 0;
    int nFail = 0;

    instruction_fetch #(.ADDR_WIDTH(64), .RESET_PC(64'h0)) dut (
        .clock(clock), .resetN(resetN), .icacheReq(icacheReq), .icacheAddr(icacheAddr),
        .icacheReady(icacheReady), .icacheData(icacheData), .instruction(instruction),
        .instructionValid(instructionValid), .pc(pc), .stall(stall),
        .redirectValid(redirectValid), .branch(branch), .unconditionalBranch(unconditionalBranch),
        .aluZero(aluZero), .branchOffset(branchOffset)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether a word is being held, whether the outstanding
    // request is to be thrown away, and where the next fetch goes.
    logic        started = 0, holding = 0, discard = 0;
    logic [63:0] reqAddr = 0, nextFetch = 0, mPc = 0;
    logic [31:0] mInstr = 0;
    logic        mTaken;
    logic [63:0] tgt;
    assign mTaken = redirectValid && (unconditionalBranch || (branch && aluZero));
    assign tgt = mPc + branchOffset * 64'd4;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            started <= 0; holding <= 0; discard <= 0;
            nextFetch <= 0; mPc <= 0; mInstr <= 0;
        end else if (!started) started <= 1;
        else if (holding) begin
            if (mTaken) begin holding <= 0; nextFetch <= tgt; end
            else if (!stall) begin holding <= 0; nextFetch <= mPc + 64'd4; end
        end else if (discard) begin
            if (mTaken) nextFetch <= tgt;
            if (icacheReady) discard <= 0;
        end else if (icacheReady) begin
            if (mTaken) nextFetch <= tgt;
            else begin holding <= 1; mPc <= nextFetch; mInstr <= icacheData; end
        end else if (mTaken) begin
            reqAddr <= nextFetch; nextFetch <= tgt; discard <= 1;
        end
    end

    always @(negedge clock) begin
        chk("m_req", {63'd0, icacheReq}, {63'd0, started && !holding});
        if (started && !holding) chk("m_addr", icacheAddr, discard ? reqAddr : nextFetch);
        chk("m_valid", {63'd0, instructionValid}, {63'd0, holding});
        chk("m_instr", {32'd0, instruction}, {32'd0, mInstr});
        chk("m_pc", pc, mPc);
    end

    task automatic clearRedirect();
        redirectValid = 0; branch = 0; unconditionalBranch = 0; aluZero = 0; branchOffset = 0;
    endtask

    task automatic doReset();
        @(negedge clock);
        resetN = 0; icacheReady = 1; stall = 0; clearRedirect();
        @(negedge clock);
        resetN = 1;
    endtask

    task automatic gotoPc(input logic [63:0] target);
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            if (icacheReq) icacheData = {16'hBEEF, icacheAddr[15:0]};
            if (instructionValid && pc == target) found = 1;
        end
        if (!found) chk("goto_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1 resetN = 0;
        // sequential fetch with a zero-wait cache
        doReset();
        chk("rst_req", {63'd0, icacheReq}, 64'd0);
        chk("rst_valid", {63'd0, instructionValid}, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_instr", {32'd0, instruction}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("seq_req", {63'd0, icacheReq}, 64'd1);
            chk("seq_addr", icacheAddr, 64'(4 * k));
            chk("seq_vlow", {63'd0, instructionValid}, 64'd0);
            icacheData = 32'hC0DE0000 | 32'(k);
            @(negedge clock);
            chk("seq_valid", {63'd0, instructionValid}, 64'd1);
            chk("seq_pc", pc, 64'(4 * k));
            chk("seq_instr", {32'd0, instruction}, {32'd0, 32'hC0DE0000 | 32'(k)});
            chk("seq_reqlow", {63'd0, icacheReq}, 64'd0);
        end
        // unconditional redirect backwards from 0x40
        doReset();
        gotoPc(64'h40);
        redirectValid = 1; unconditionalBranch = 1; branchOffset = -64'sd4;
        @(negedge clock);
        chk("jmp_valid", {63'd0, instructionValid}, 64'd0);
        chk("jmp_addr", icacheAddr, 64'h30);
        // redirect to 0x100 while the cache is stalled
        icacheReady = 0; branchOffset = 64'h30;
        @(negedge clock);
        clearRedirect();
        chk("fl_addr1", icacheAddr, 64'h30);
        chk("fl_req1", {63'd0, icacheReq}, 64'd1);
        @(negedge clock);
        chk("fl_addr2", icacheAddr, 64'h30);
        @(negedge clock);
        chk("fl_addr3", icacheAddr, 64'h30);
        icacheReady = 1; icacheData = 32'hDEADBEEF;
        @(negedge clock);
        chk("fl_newaddr", icacheAddr, 64'h100);
        chk("fl_vlow", {63'd0, instructionValid}, 64'd0);
        icacheData = 32'h11112222;
        @(negedge clock);
        chk("fl_pc", pc, 64'h100);
        chk("fl_instr", {32'd0, instruction}, 64'h11112222);
        // downstream stall holds the presented word
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("st_valid", {63'd0, instructionValid}, 64'd1);
            chk("st_pc", pc, 64'h100);
            chk("st_instr", {32'd0, instruction}, 64'h11112222);
            chk("st_req", {63'd0, icacheReq}, 64'd0);
        end
        stall = 0;
        @(negedge clock);
        chk("st_next", icacheAddr, 64'h104);
        icacheData = 32'h55555555;
        @(negedge clock);
        chk("nt_pc", pc, 64'h104);
        redirectValid = 1; branch = 1; aluZero = 0; branchOffset = 64'd100;
        @(negedge clock);
        clearRedirect();
        chk("nt_addr", icacheAddr, 64'h108);
        // taken conditional branch
        doReset();
        gotoPc(64'h10);
        redirectValid = 1; branch = 1; aluZero = 1; branchOffset = 64'd2;
        @(negedge clock);
        clearRedirect();
        chk("br_addr", icacheAddr, 64'h18);
        // reset while a flushed request is outstanding
        icacheReady = 0; redirectValid = 1; unconditionalBranch = 1; branchOffset = 64'h10;
        @(negedge clock);
        clearRedirect();
        chk("rf_req", {63'd0, icacheReq}, 64'd1);
        chk("rf_addr", icacheAddr, 64'h18);
        #2 resetN = 0;
        #1;
        chk("rf_async_req", {63'd0, icacheReq}, 64'd0);
        chk("rf_async_valid", {63'd0, instructionValid}, 64'd0);
        chk("rf_async_pc", pc, 64'd0);
        @(negedge clock);
        resetN = 1; icacheReady = 1;
        @(negedge clock);
        chk("rf_first", icacheAddr, 64'd0);
        // randomized traffic against the model
        doReset();
        repeat (3000) begin
            @(negedge clock);
            icacheReady = ($urandom % 4) != 0;
            icacheData = $urandom;
            stall = ($urandom % 3) == 0;
            redirectValid = ($urandom % 4) == 0;
            branch = $urandom % 2;
            unconditionalBranch = ($urandom % 3) == 0;
            aluZero = $urandom % 2;
            branchOffset = 64'($signed($urandom_range(0, 127)) - 64);
        end
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
